washing_machine_ctrl_param: RTL and testbench
=============================================

Name: washing_machine_ctrl_param

Overview:
- Parametrised successor to the automatic washing-machine FSM.
- Internal wash and spin timers replace the external Cycle_Timeout/Spin_Timeout inputs.
- Adds a programmable number of rinse passes, fill/drain watchdogs, an abort request, and a fault state.
- Sits between the front-panel/sensor inputs and the motor, valve and lock drivers; one instance per machine.

Parameters:
- TIMER_W, 16: width of the wash/spin duration inputs and internal timer.
- RINSE_W, 2: width of the rinse-count input (up to 2^RINSE_W-1 rinses).
- FILL_LIMIT, 1000: maximum cycles in FILL before fault.
- DRAIN_LIMIT, 1000: maximum cycles in DRAIN before fault.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-low reset (0 = reset, sampled on the rising Clock edge).
- Start  in  1  level request to begin a program.
- Door_Close  in  1  door-closed sensor.
- Filled  in  1  water-level-full sensor.
- Drained  in  1  water-empty sensor.
- Detergent_Added  in  1  detergent-dispensed sensor.
- Abort  in  1  user cancel.
- Wash_Time  in  TIMER_W  wash/rinse agitation duration in cycles; latched at start.
- Spin_Time  in  TIMER_W  spin duration in cycles; latched at start.
- Rinse_Count  in  RINSE_W  number of rinse passes; latched at start.
- Motor_on  out  1  drum motor enable.
- Fill_valve_on  out  1  inlet valve enable.
- Drained_valve_on  out  1  drain valve enable.
- Door_Lock  out  1  door lock solenoid.
- Done  out  1  program complete.
- Error  out  1  fault indication.
- State  out  3  current state encoding, for debug.
- Rinse_Left  out  RINSE_W  remaining rinse passes.

Behaviour:
- Reset (Reset=0 at an edge) forces state to IDLE, clears timers and Rinse_Left, and clears all latched times. Overrides everything, including mid-program.
- In IDLE, all outputs are 0.
- Outputs are a Moore decode of the state register. An output changes in the cycle after the edge that enters the state.
- State encoding:
  - IDLE=0, FILL=1, ADD_DET=2, WASH=3, DRAIN=4, SPIN=5, DONE=6, FAULT=7.
- Output decode per state:
  - FILL: Fill_valve_on=1, Door_Lock=1.
  - ADD_DET: Door_Lock=1.
  - WASH: Motor_on=1, Door_Lock=1.
  - DRAIN: Drained_valve_on=1, Door_Lock=1.
  - SPIN: Motor_on=1, Drained_valve_on=1, Door_Lock=1.
  - DONE: Done=1.
  - FAULT: Error=1, Drained_valve_on=1, Door_Lock=!Drained.
- Internal flag rinse_phase (0 on the first pass).
- Transitions:
  - IDLE -> FILL when Start=1 and Door_Close=1. On this edge, latch Wash_Time, Spin_Time and Rinse_Count (into Rinse_Left), and clear rinse_phase. Start with the door open: remain in IDLE.
  - FILL -> (rinse_phase ? WASH : ADD_DET) when Filled=1.
  - FILL -> FAULT after FILL_LIMIT cycles in FILL without Filled.
  - ADD_DET -> WASH when Detergent_Added=1. No timeout.
  - WASH occupies exactly max(latched Wash_Time, 1) cycles, then goes to DRAIN. The timer is loaded on entry.
  - DRAIN, once Drained=1:
    - If Rinse_Left>0 and no abort is pending: decrement Rinse_Left, set rinse_phase, go to FILL.
    - Otherwise go to SPIN. If an abort is pending, go to DONE instead.
  - DRAIN -> FAULT after DRAIN_LIMIT cycles without Drained.
  - SPIN occupies exactly max(latched Spin_Time, 1) cycles, then goes to DONE.
  - DONE -> IDLE when Start=0. Done stays 1 while Start is held.
  - FAULT is exited only by reset.
- Abort=1 in FILL, ADD_DET, WASH or SPIN:
  - next state is DRAIN, the abort-pending flag is set, and Rinse_Left is cleared;
  - the abort is ignored in IDLE, DONE and FAULT;
  - Abort in DRAIN sets the pending flag only.
- Door_Close=0 in any state other than IDLE, DONE and FAULT -> FAULT next edge. This takes priority over Abort and all other transitions.
- Simultaneous watchdog expiry and sensor arrival on the same edge: the sensor wins.
- Timers saturate and do not wrap. Changing Wash_Time, Spin_Time or Rinse_Count mid-program has no effect.

Test Plan:
- Nominal, no rinse: Wash_Time=4, Spin_Time=3, Rinse_Count=0.
  - Start with door closed, then Filled, then Detergent_Added.
  - Required: Motor_on high for exactly 4 cycles in WASH, then DRAIN; after Drained, SPIN shows Motor_on and Drained_valve_on for 3 cycles, then Done=1.
  - Drop Start -> IDLE.
- Two rinses: Rinse_Count=2.
  - Required: state sequence FILL, ADD_DET, WASH, DRAIN, FILL, WASH, DRAIN, FILL, WASH, DRAIN, SPIN, DONE.
  - Rinse_Left steps 2 -> 1 -> 0; ADD_DET occurs only once.
- Zero duration: Wash_Time=0, Spin_Time=0.
  - Required: WASH and SPIN each last exactly 1 cycle.
- Watchdog, FILL_LIMIT=8: Filled held 0.
  - Required: FAULT entered after 8 FILL cycles; Error=1 and Drained_valve_on=1; Door_Lock=1 until Drained=1, then 0.
  - Only Reset=0 returns to IDLE.
- Abort in WASH with Rinse_Count=3: pulse Abort.
  - Required: next state DRAIN, Rinse_Left=0; after Drained, go to DONE (no SPIN, no FILL).
- Door opened in WASH, and reset mid-program:
  - Door_Close=0 during WASH -> FAULT next edge.
  - Separately, Reset=0 during SPIN -> all outputs 0 and State=0 after that edge; Reset=0 between edges has no effect until the next edge.

Source files
------------

// File: rtl/washing_machine_ctrl_param.sv
// rtl/washing_machine_ctrl_param.sv - parametrised washing-machine program controller
//
// Sequences fill, detergent, wash, rinse passes, drain and spin with internal
// timers, fill/drain watchdogs, a user abort and a latched fault state.
//
// Ports:
//   Clock, Reset            clock and synchronous active-low reset
//   Start, Door_Close       program request and door-closed sensor
//   Filled, Drained         water level sensors
//   Detergent_Added, Abort  detergent sensor and user cancel
//   Wash_Time, Spin_Time    agitation / spin durations in cycles (latched at start)
//   Rinse_Count             number of rinse passes (latched at start)
//   Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock  actuator drives
//   Done, Error             program complete / fault
//   State, Rinse_Left       debug view of state and remaining rinses
module washing_machine_ctrl_param #(
    parameter int TIMER_W     = 16,
    parameter int RINSE_W     = 2,
    parameter int FILL_LIMIT  = 1000,
    parameter int DRAIN_LIMIT = 1000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Door_Close,
    input  logic               Filled,
    input  logic               Drained,
    input  logic               Detergent_Added,
    input  logic               Abort,
    input  logic [TIMER_W-1:0] Wash_Time,
    input  logic [TIMER_W-1:0] Spin_Time,
    input  logic [RINSE_W-1:0] Rinse_Count,
    output logic               Motor_on,
    output logic               Fill_valve_on,
    output logic               Drained_valve_on,
    output logic               Door_Lock,
    output logic               Done,
    output logic               Error,
    output logic [2:0]         State,
    output logic [RINSE_W-1:0] Rinse_Left
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        ADD_DET = 3'd2,
        WASH    = 3'd3,
        DRAIN   = 3'd4,
        SPIN    = 3'd5,
        DONE    = 3'd6,
        FAULT   = 3'd7
    } state_t;

    localparam int WD_MAX = (FILL_LIMIT > DRAIN_LIMIT) ? FILL_LIMIT : DRAIN_LIMIT;
    localparam int WD_W   = $clog2(WD_MAX + 1);
    localparam logic [WD_W-1:0] FILL_LAST  = WD_W'(FILL_LIMIT - 1);
    localparam logic [WD_W-1:0] DRAIN_LAST = WD_W'(DRAIN_LIMIT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] r_wash_time;
    logic [TIMER_W-1:0] r_spin_time;
    logic [RINSE_W-1:0] r_rinse_left;
    logic               r_rinse_phase;
    logic               r_abort_pend;
    logic [WD_W-1:0]    r_wd;

    logic               w_start;
    logic               w_rinse_step;
    logic               w_abort_take;
    logic               w_pend;
    logic [TIMER_W-1:0] w_wash_load;
    logic [TIMER_W-1:0] w_spin_load;

    // An abort raised while already draining counts as pending on the same edge.
    assign w_pend      = r_abort_pend | ((r_state == DRAIN) && Abort);
    // Zero duration still occupies one cycle.
    assign w_wash_load = (r_wash_time == '0) ? TIMER_W'(1) : r_wash_time;
    assign w_spin_load = (r_spin_time == '0) ? TIMER_W'(1) : r_spin_time;

    always_comb begin
        w_next           = r_state;
        w_start          = 1'b0;
        w_rinse_step     = 1'b0;
        w_abort_take     = 1'b0;
        Motor_on         = 1'b0;
        Fill_valve_on    = 1'b0;
        Drained_valve_on = 1'b0;
        Door_Lock        = 1'b0;
        Done             = 1'b0;
        Error            = 1'b0;

        // Door open beats abort, sensors and watchdogs; sensors beat watchdogs.
        case (r_state)
            IDLE: begin
                if (Start && Door_Close) begin
                    w_next  = FILL;
                    w_start = 1'b1;
                end
            end
            FILL: begin
                if (!Door_Close)          w_next = FAULT;
                else if (Abort)           begin w_next = DRAIN; w_abort_take = 1'b1; end
                else if (Filled)          w_next = r_rinse_phase ? WASH : ADD_DET;
                else if (r_wd == FILL_LAST) w_next = FAULT;
            end
            ADD_DET: begin
                if (!Door_Close)          w_next = FAULT;
                else if (Abort)           begin w_next = DRAIN; w_abort_take = 1'b1; end
                else if (Detergent_Added) w_next = WASH;
            end
            WASH: begin
                if (!Door_Close)          w_next = FAULT;
                else if (Abort)           begin w_next = DRAIN; w_abort_take = 1'b1; end
                else if (r_timer <= TIMER_W'(1)) w_next = DRAIN;
            end
            DRAIN: begin
                if (!Door_Close)          w_next = FAULT;
                else if (Drained) begin
                    if (w_pend)                  w_next = DONE;
                    else if (r_rinse_left != '0) begin w_next = FILL; w_rinse_step = 1'b1; end
                    else                         w_next = SPIN;
                end
                else if (r_wd == DRAIN_LAST) w_next = FAULT;
            end
            SPIN: begin
                if (!Door_Close)          w_next = FAULT;
                else if (Abort)           begin w_next = DRAIN; w_abort_take = 1'b1; end
                else if (r_timer <= TIMER_W'(1)) w_next = DONE;
            end
            DONE: begin
                if (!Start) w_next = IDLE;
            end
            default: w_next = FAULT;
        endcase

        case (r_state)
            FILL:    begin Fill_valve_on = 1'b1; Door_Lock = 1'b1; end
            ADD_DET: Door_Lock = 1'b1;
            WASH:    begin Motor_on = 1'b1; Door_Lock = 1'b1; end
            DRAIN:   begin Drained_valve_on = 1'b1; Door_Lock = 1'b1; end
            SPIN:    begin Motor_on = 1'b1; Drained_valve_on = 1'b1; Door_Lock = 1'b1; end
            DONE:    Done = 1'b1;
            FAULT:   begin Error = 1'b1; Drained_valve_on = 1'b1; Door_Lock = !Drained; end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state       <= IDLE;
            r_timer       <= '0;
            r_wash_time   <= '0;
            r_spin_time   <= '0;
            r_rinse_left  <= '0;
            r_rinse_phase <= 1'b0;
            r_abort_pend  <= 1'b0;
            r_wd          <= '0;
        end else begin
            r_state <= w_next;

            // Watchdog counts cycles spent in the current state, saturating.
            if (w_next != r_state)  r_wd <= '0;
            else if (r_wd != '1)    r_wd <= r_wd + 1'b1;

            if (w_next == WASH && r_state != WASH)
                r_timer <= w_wash_load;
            else if (w_next == SPIN && r_state != SPIN)
                r_timer <= w_spin_load;
            else if ((r_state == WASH || r_state == SPIN) && r_timer != '0)
                r_timer <= r_timer - 1'b1;

            if (w_start) begin
                r_wash_time   <= Wash_Time;
                r_spin_time   <= Spin_Time;
                r_rinse_left  <= Rinse_Count;
                r_rinse_phase <= 1'b0;
                r_abort_pend  <= 1'b0;
            end else begin
                if (w_rinse_step) begin
                    r_rinse_left  <= r_rinse_left - 1'b1;
                    r_rinse_phase <= 1'b1;
                end
                if (w_abort_take) begin
                    r_abort_pend <= 1'b1;
                    r_rinse_left <= '0;
                end
                if (r_state == DRAIN && Abort)
                    r_abort_pend <= 1'b1;
            end
        end
    end

    assign State      = r_state;
    assign Rinse_Left = r_rinse_left;

endmodule

// File: tb/tb_washing_machine_ctrl_param.sv
// tb/tb_washing_machine_ctrl_param.sv - scoreboard bench for washing_machine_ctrl_param
module tb_washing_machine_ctrl_param;

    localparam logic [2:0] S_IDLE = 3'd0, S_FILL = 3'd1, S_ADD = 3'd2, S_WASH = 3'd3,
                           S_DRAIN = 3'd4, S_SPIN = 3'd5, S_DONE = 3'd6, S_FAULT = 3'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, door = 1'b0, filled = 1'b0, drained = 1'b0, det = 1'b0, abort_i = 1'b0;
    logic [15:0] wash_t = '0, spin_t = '0;
    logic [1:0]  rinse_c = '0;
    logic        motor, fillv, drainv, lock, done, err;
    logic [2:0]  state;
    logic [1:0]  rinse_left;

    washing_machine_ctrl_param #(
        .TIMER_W(16), .RINSE_W(2), .FILL_LIMIT(8), .DRAIN_LIMIT(8)
    ) dut (
        .Clock(clk), .Reset(rst_n), .Start(start), .Door_Close(door),
        .Filled(filled), .Drained(drained), .Detergent_Added(det), .Abort(abort_i),
        .Wash_Time(wash_t), .Spin_Time(spin_t), .Rinse_Count(rinse_c),
        .Motor_on(motor), .Fill_valve_on(fillv), .Drained_valve_on(drainv),
        .Door_Lock(lock), .Done(done), .Error(err), .State(state), .Rinse_Left(rinse_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [1:0] rl;
        int         tst;
        int         idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cur_test = 0;
    int   step_idx = 0;

    // {Motor_on, Fill_valve_on, Drained_valve_on, Door_Lock, Done, Error}
    function automatic logic [5:0] decode(input logic [2:0] st, input logic dr);
        case (st)
            S_FILL:  return 6'b010100;
            S_ADD:   return 6'b000100;
            S_WASH:  return 6'b100100;
            S_DRAIN: return 6'b001100;
            S_SPIN:  return 6'b101100;
            S_DONE:  return 6'b000010;
            S_FAULT: return {3'b001, ~dr, 2'b01};
            default: return 6'b000000;
        endcase
    endfunction

    // Advance one clock edge, then expect the given state / rinse count.
    task automatic tick(input logic [2:0] st, input logic [1:0] rl);
        exp_t e;
        @(posedge clk);
        #1;
        e.st = st; e.rl = rl; e.tst = cur_test; e.idx = step_idx;
        q.push_back(e);
        step_idx++;
    endtask

    task automatic begin_test(input int n);
        cur_test = n;
        step_idx = 0;
    endtask

    // Monitor: the DUT presents a Moore output every cycle; compare mid-cycle.
    exp_t       m_e;
    logic [5:0] m_exp_o, m_got_o;
    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e     = q.pop_front();
            m_exp_o = decode(m_e.st, drained);
            m_got_o = {motor, fillv, drainv, lock, done, err};
            checks++;
            if (state !== m_e.st || rinse_left !== m_e.rl || m_got_o !== m_exp_o) begin
                failures++;
                $display("FAIL t%0d_step%0d: got state=%0d rl=%0d out=%b, want state=%0d rl=%0d out=%b",
                         m_e.tst, m_e.idx, state, rinse_left, m_got_o, m_e.st, m_e.rl, m_exp_o);
            end
        end
    end

    initial begin
        // reset state
        begin_test(0);
        rst_n = 1'b0;
        tick(S_IDLE, 0);
        tick(S_IDLE, 0);
        rst_n = 1'b1;
        door = 1'b0; start = 1'b1;          // start with door open stays idle
        tick(S_IDLE, 0);
        start = 1'b0; door = 1'b1;
        tick(S_IDLE, 0);

        // nominal, no rinse
        begin_test(1);
        wash_t = 16'd4; spin_t = 16'd3; rinse_c = 2'd0; start = 1'b1;
        tick(S_FILL, 0);
        wash_t = 16'd9;                     // mid-program change has no effect
        tick(S_FILL, 0);
        filled = 1'b1;  tick(S_ADD, 0);
        filled = 1'b0; det = 1'b1; tick(S_WASH, 0);
        det = 1'b0;
        tick(S_WASH, 0); tick(S_WASH, 0); tick(S_WASH, 0);
        tick(S_DRAIN, 0);
        tick(S_DRAIN, 0);
        drained = 1'b1; tick(S_SPIN, 0);
        drained = 1'b0;
        tick(S_SPIN, 0); tick(S_SPIN, 0);
        tick(S_DONE, 0);
        tick(S_DONE, 0);
        start = 1'b0; tick(S_IDLE, 0);

        // two rinses
        begin_test(2);
        wash_t = 16'd1; spin_t = 16'd1; rinse_c = 2'd2; start = 1'b1;
        tick(S_FILL, 2);
        filled = 1'b1; tick(S_ADD, 2);
        filled = 1'b0; det = 1'b1; tick(S_WASH, 2);
        det = 1'b0; tick(S_DRAIN, 2);
        drained = 1'b1; tick(S_FILL, 1);
        drained = 1'b0; filled = 1'b1; tick(S_WASH, 1);
        filled = 1'b0; tick(S_DRAIN, 1);
        drained = 1'b1; tick(S_FILL, 0);
        drained = 1'b0; filled = 1'b1; tick(S_WASH, 0);
        filled = 1'b0; tick(S_DRAIN, 0);
        drained = 1'b1; tick(S_SPIN, 0);
        drained = 1'b0; tick(S_DONE, 0);
        start = 1'b0; tick(S_IDLE, 0);

        // zero durations
        begin_test(3);
        wash_t = 16'd0; spin_t = 16'd0; rinse_c = 2'd0; start = 1'b1;
        tick(S_FILL, 0);
        filled = 1'b1; tick(S_ADD, 0);
        filled = 1'b0; det = 1'b1; tick(S_WASH, 0);
        det = 1'b0; tick(S_DRAIN, 0);
        drained = 1'b1; tick(S_SPIN, 0);
        drained = 1'b0; tick(S_DONE, 0);
        start = 1'b0; tick(S_IDLE, 0);

        // fill watchdog
        begin_test(4);
        start = 1'b1;
        for (int i = 0; i < 8; i++) tick(S_FILL, 0);
        tick(S_FAULT, 0);
        start = 1'b0; tick(S_FAULT, 0);
        drained = 1'b1; tick(S_FAULT, 0);
        tick(S_FAULT, 0);
        rst_n = 1'b0; tick(S_IDLE, 0);
        rst_n = 1'b1; drained = 1'b0; tick(S_IDLE, 0);

        // abort in wash
        begin_test(5);
        wash_t = 16'd5; spin_t = 16'd3; rinse_c = 2'd3; start = 1'b1;
        tick(S_FILL, 3);
        filled = 1'b1; tick(S_ADD, 3);
        filled = 1'b0; det = 1'b1; tick(S_WASH, 3);
        det = 1'b0; tick(S_WASH, 3);
        abort_i = 1'b1; tick(S_DRAIN, 0);
        abort_i = 1'b0; tick(S_DRAIN, 0);
        drained = 1'b1; tick(S_DONE, 0);
        drained = 1'b0; start = 1'b0; tick(S_IDLE, 0);

        // door opened in wash
        begin_test(6);
        wash_t = 16'd5; rinse_c = 2'd0; start = 1'b1;
        tick(S_FILL, 0);
        filled = 1'b1; tick(S_ADD, 0);
        filled = 1'b0; det = 1'b1; tick(S_WASH, 0);
        det = 1'b0; door = 1'b0; tick(S_FAULT, 0);
        door = 1'b1; tick(S_FAULT, 0);
        rst_n = 1'b0; start = 1'b0; tick(S_IDLE, 0);
        rst_n = 1'b1; tick(S_IDLE, 0);

        // reset during spin, with a glitch between edges first
        begin_test(7);
        wash_t = 16'd1; spin_t = 16'd6; rinse_c = 2'd1; start = 1'b1;
        tick(S_FILL, 1);
        filled = 1'b1; tick(S_ADD, 1);
        filled = 1'b0; det = 1'b1; tick(S_WASH, 1);
        det = 1'b0; tick(S_DRAIN, 1);
        drained = 1'b1; tick(S_FILL, 0);
        drained = 1'b0; filled = 1'b1; tick(S_WASH, 0);
        filled = 1'b0; tick(S_DRAIN, 0);
        drained = 1'b1; tick(S_SPIN, 0);
        drained = 1'b0; tick(S_SPIN, 0);
        rst_n = 1'b0; #2; rst_n = 1'b1;
        tick(S_SPIN, 0);
        rst_n = 1'b0; tick(S_IDLE, 0);
        rst_n = 1'b1; start = 1'b0; tick(S_IDLE, 0);

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
